// File: rtl/cc1200_tx_framer_pkg.sv
// Shared types and constants for the CC1200 TX framer: FSM states, default
// sync words, the burst-TX-FIFO command byte and the fixed header length.
package cc1200_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO,
        GAP
    } state_t;

    localparam logic [31:0] DEF_SYNC0    = 32'h93AAAADE;
    localparam logic [31:0] DEF_SYNC1    = 32'h935555DE;
    localparam logic [7:0]  DEF_CMD      = 8'h7F;
    localparam logic [7:0]  HDR_LEN      = 8'd7;
    localparam logic [7:0]  MIN_PKT_SIZE = 8'd8;

    // A packet always carries the full header plus at least one payload byte.
    function automatic logic [7:0] eff_size(input logic [7:0] req);
        return (req < MIN_PKT_SIZE) ? MIN_PKT_SIZE : req;
    endfunction

endpackage

// File: rtl/cc1200_tx_framer_if.sv
// Sample stream and SPI byte handshake between the framer and its neighbours.
// master = framer side, slave = sample source / SPI engine side.
interface cc1200_tx_framer_if #(
    parameter int SAMPLE_W = 12
);
    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic                load_next;
    logic                spi_start;
    logic                spi_stop;
    logic [7:0]          spi_byte;

    modport master (
        input  s_data,
        input  s_valid,
        input  load_next,
        output s_ready,
        output spi_start,
        output spi_stop,
        output spi_byte
    );

    modport slave (
        output s_data,
        output s_valid,
        output load_next,
        input  s_ready,
        input  spi_start,
        input  spi_stop,
        input  spi_byte
    );
endinterface

// File: rtl/cc1200_tx_framer_bit_packer.sv
// LSB-first bit packer: turns SAMPLE_W-bit samples into a byte stream,
// pulling a new sample only when fewer than 8 bits are buffered.
module cc1200_bit_packer #(
    parameter int SAMPLE_W = 12
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_clear,
    input  logic                i_advance,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_sample_valid,
    output logic                o_sample_ready,
    output logic                o_starve,
    output logic [7:0]          o_byte
);

    localparam int ACC_W = SAMPLE_W + 7;

    logic [ACC_W-1:0]    r_acc;
    logic [4:0]          r_nbits;

    logic                w_need;
    logic [SAMPLE_W-1:0] w_fill;
    logic [ACC_W-1:0]    w_merged;
    logic [4:0]          w_nbits_merged;

    // A missing sample is replaced by zeros so the byte stream never stalls.
    always_comb begin
        w_need         = (r_nbits < 5'd8);
        w_fill         = (w_need && i_sample_valid) ? i_sample : '0;
        w_merged       = r_acc | ({{7{1'b0}}, w_fill} << r_nbits);
        w_nbits_merged = w_need ? (r_nbits + 5'(SAMPLE_W)) : r_nbits;
        o_byte         = w_merged[7:0];
        o_sample_ready = i_advance && w_need && i_sample_valid;
        o_starve       = i_advance && w_need && !i_sample_valid;
    end

    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            r_acc   <= '0;
            r_nbits <= '0;
        end else if (i_advance) begin
            r_acc   <= w_merged >> 8;
            r_nbits <= w_nbits_merged - 5'd8;
        end
    end

endmodule

// File: rtl/cc1200_tx_framer.sv
// CC1200 TX framer: emits CMD, sync word, address and packed payload bytes to
// an SPI engine, then waits for the packet-sent GPIO and an inter-packet gap.
module cc1200_tx_framer
    import cc1200_pkg::*;
#(
    parameter int          SAMPLE_W = 12,
    parameter logic [31:0] SYNC0    = DEF_SYNC0,
    parameter logic [31:0] SYNC1    = DEF_SYNC1,
    parameter logic [7:0]  CMD      = DEF_CMD
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  trans_en,
    input  logic                  tran_en,
    input  logic                  frame_sync,
    input  logic [15:0]           tran_add,
    input  logic [7:0]            tx_pkt_size,
    input  logic [15:0]           tx_wait,
    input  logic                  pkt_gpio,
    output logic                  busy,
    output logic                  underrun,
    cc1200_tx_framer_if.master    bus
);

    state_t      r_state;
    logic [7:0]  r_byte_cnt;
    logic [7:0]  r_size;
    logic        r_sync_sel;
    logic [15:0] r_add;
    logic [15:0] r_gap_cnt;
    logic        r_underrun;
    logic        r_gpio_meta;
    logic        r_gpio_sync;

    state_t      w_next;
    logic        w_start;
    logic        w_last;
    logic        w_advance;
    logic        w_payload_adv;
    logic        w_starve;
    logic        w_sample_ready;
    logic [7:0]  w_pack_byte;
    logic [31:0] w_sync;
    logic [7:0]  w_spi_byte;

    // Handshakes are gated by rstn so nothing is started or consumed in a reset cycle.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_last    = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            IDLE: begin
                if (rstn && trans_en && tran_en) begin
                    w_next  = SEND;
                    w_start = 1'b1;
                end
            end
            SEND: begin
                w_last = (r_byte_cnt == r_size - 8'd1);
                if (rstn && bus.load_next) begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_next = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (r_gpio_sync) begin
                    w_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!r_gpio_sync) begin
                    w_next = GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == tx_wait) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_payload_adv = w_advance && (r_byte_cnt >= HDR_LEN);
    assign w_sync        = r_sync_sel ? SYNC1 : SYNC0;

    cc1200_bit_packer #(
        .SAMPLE_W (SAMPLE_W)
    ) u_packer (
        .clk            (clk),
        .rstn           (rstn),
        .i_clear        (w_start),
        .i_advance      (w_payload_adv),
        .i_sample       (bus.s_data),
        .i_sample_valid (bus.s_valid),
        .o_sample_ready (w_sample_ready),
        .o_starve       (w_starve),
        .o_byte         (w_pack_byte)
    );

    always_comb begin
        w_spi_byte = 8'h00;
        if (r_state == SEND) begin
            case (r_byte_cnt)
                8'd0:    w_spi_byte = CMD;
                8'd1:    w_spi_byte = w_sync[31:24];
                8'd2:    w_spi_byte = w_sync[23:16];
                8'd3:    w_spi_byte = w_sync[15:8];
                8'd4:    w_spi_byte = w_sync[7:0];
                8'd5:    w_spi_byte = r_add[15:8];
                8'd6:    w_spi_byte = r_add[7:0];
                default: w_spi_byte = w_pack_byte;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_byte_cnt  <= '0;
            r_size      <= '0;
            r_sync_sel  <= 1'b0;
            r_add       <= '0;
            r_gap_cnt   <= '0;
            r_underrun  <= 1'b0;
            r_gpio_meta <= 1'b0;
            r_gpio_sync <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_gpio_meta <= pkt_gpio;
            r_gpio_sync <= r_gpio_meta;
            if (w_start) begin
                r_byte_cnt <= '0;
                r_size     <= eff_size(tx_pkt_size);
                r_sync_sel <= frame_sync;
                r_add      <= tran_add;
                r_underrun <= 1'b0;
            end else if (w_advance) begin
                r_byte_cnt <= r_byte_cnt + 8'd1;
            end
            if (w_starve) begin
                r_underrun <= 1'b1;
            end
            // Gap counter runs 0..tx_wait inclusive, so tx_wait=0 still spends one cycle in GAP.
            if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + 16'd1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign bus.spi_start = w_start;
    assign bus.spi_stop  = w_last;
    assign bus.spi_byte  = w_spi_byte;
    assign bus.s_ready   = w_sample_ready;
    assign busy          = (r_state != IDLE);
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_cc1200_tx_framer.sv
// Directed self-checking bench for cc1200_tx_framer: header/payload byte order,
// size clamp, underrun, GPIO/gap timing and mid-packet reset.
module tb_cc1200_tx_framer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        trans_en;
    logic        tran_en;
    logic        frame_sync;
    logic [15:0] tran_add;
    logic [7:0]  tx_pkt_size;
    logic [15:0] tx_wait;
    logic        pkt_gpio;
    logic        busy;
    logic        underrun;

    cc1200_tx_framer_if #(.SAMPLE_W(12)) bus ();

    cc1200_tx_framer #(.SAMPLE_W(12)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .trans_en    (trans_en),
        .tran_en     (tran_en),
        .frame_sync  (frame_sync),
        .tran_add    (tran_add),
        .tx_pkt_size (tx_pkt_size),
        .tx_wait     (tx_wait),
        .pkt_gpio    (pkt_gpio),
        .busy        (busy),
        .underrun    (underrun),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] expBytes [0:15];
    logic [11:0] samples [0:7];
    int         nSamples = 0;
    int         sIdx     = 0;
    bit         sValidEn = 1'b1;
    logic       expUnderrun = 1'b0;

    task automatic update_stream();
        bus.s_valid = sValidEn && (sIdx < nSamples);
        bus.s_data  = (sIdx < nSamples) ? samples[sIdx] : 12'h000;
    endtask

    task automatic start_packet(input logic fs, input logic [15:0] add, input logic [7:0] size);
        @(negedge clk);
        frame_sync  = fs;
        tran_add    = add;
        tx_pkt_size = size;
        trans_en    = 1'b1;
        tran_en     = 1'b1;
        #1;
        checks++;
        if (bus.spi_start !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_pulse: got %b want 1", bus.spi_start);
        end
        @(posedge clk);
        #1;
        // Scramble the per-packet inputs to prove they were latched at start.
        tran_en     = 1'b0;
        frame_sync  = ~fs;
        tran_add    = ~add;
        tx_pkt_size = 8'd200;
        checks++;
        if (bus.spi_start !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_after: spi_start=%b busy=%b want 0/1", bus.spi_start, busy);
        end
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL underrun_clear_at_start: got %b want 0", underrun);
        end
    endtask

    task automatic run_packet(input int nBytes, input int nRun);
        for (int i = 0; i < nRun; i++) begin
            logic expStop;
            logic expUr;
            logic took;
            expStop = (i == nBytes - 1);
            expUr   = (i > 7) ? expUnderrun : 1'b0;
            @(negedge clk);
            if (i % 4 == 2) begin
                bus.load_next = 1'b0;
                #1;
                checks++;
                if (bus.spi_byte !== expBytes[i]) begin
                    failures++;
                    $display("[TB] FAIL stall_byte[%0d]: got %h want %h", i, bus.spi_byte, expBytes[i]);
                end
                @(negedge clk);
            end
            bus.load_next = 1'b1;
            #1;
            checks++;
            if (bus.spi_byte !== expBytes[i]) begin
                failures++;
                $display("[TB] FAIL byte[%0d]: got %h want %h", i, bus.spi_byte, expBytes[i]);
            end
            checks++;
            if (bus.spi_stop !== expStop) begin
                failures++;
                $display("[TB] FAIL stop[%0d]: got %b want %b", i, bus.spi_stop, expStop);
            end
            checks++;
            if (underrun !== expUr) begin
                failures++;
                $display("[TB] FAIL underrun[%0d]: got %b want %b", i, underrun, expUr);
            end
            took = bus.s_ready && bus.s_valid;
            @(posedge clk);
            #1;
            bus.load_next = 1'b0;
            if (took) begin
                sIdx++;
                update_stream();
            end
        end
    endtask

    task automatic finish_packet(input int hiCycles, input int expEdges, input bit reqDuringGap);
        int n;
        bit sawStart;
        n        = 0;
        sawStart = 1'b0;
        @(negedge clk);
        pkt_gpio = 1'b1;
        if (reqDuringGap) begin
            trans_en = 1'b1;
            tran_en  = 1'b1;
        end
        repeat (hiCycles) @(negedge clk);
        pkt_gpio = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy === 1'b1 && bus.spi_start !== 1'b0) sawStart = 1'b1;
        end
        checks++;
        if (n != expEdges || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_drop: got %0d edges busy=%b want %0d edges busy=0", n, busy, expEdges);
        end
        if (reqDuringGap) begin
            checks++;
            if (sawStart) begin
                failures++;
                $display("[TB] FAIL start_while_busy: got 1 want 0");
            end
            checks++;
            if (bus.spi_start !== 1'b1) begin
                failures++;
                $display("[TB] FAIL start_once_idle: got %b want 1", bus.spi_start);
            end
            tran_en = 1'b0;
        end
    endtask

    task automatic load_basic();
        samples[0] = 12'hABC; samples[1] = 12'h123;
        samples[2] = 12'h456; samples[3] = 12'h789;
        nSamples = 4; sIdx = 0; sValidEn = 1'b1; expUnderrun = 1'b0;
        update_stream();
        expBytes[0]  = 8'h7F; expBytes[1]  = 8'h93; expBytes[2]  = 8'hAA;
        expBytes[3]  = 8'hAA; expBytes[4]  = 8'hDE; expBytes[5]  = 8'h12;
        expBytes[6]  = 8'h34; expBytes[7]  = 8'hBC; expBytes[8]  = 8'h3A;
        expBytes[9]  = 8'h12; expBytes[10] = 8'h56; expBytes[11] = 8'h94;
        expBytes[12] = 8'h78;
    endtask

    task automatic test_reset();
        rstn = 1'b0; trans_en = 1'b0; tran_en = 1'b0; frame_sync = 1'b0;
        tran_add = '0; tx_pkt_size = '0; tx_wait = '0; pkt_gpio = 1'b0;
        bus.load_next = 1'b1; bus.s_valid = 1'b1; bus.s_data = 12'hFFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || underrun !== 1'b0 || bus.spi_start !== 1'b0 || bus.spi_stop !== 1'b0
            || bus.s_ready !== 1'b0 || bus.spi_byte !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_state: busy=%b ur=%b start=%b stop=%b rdy=%b byte=%h want all 0",
                     busy, underrun, bus.spi_start, bus.spi_stop, bus.s_ready, bus.spi_byte);
        end
        @(negedge clk);
        rstn = 1'b1;
        bus.load_next = 1'b0;
    endtask

    task automatic test_basic_frame();
        load_basic();
        tx_wait = 16'd0;
        start_packet(1'b0, 16'h1234, 8'd13);
        run_packet(13, 13);
        checks++;
        if (sIdx != 4) begin
            failures++;
            $display("[TB] FAIL samples_used: got %0d want 4", sIdx);
        end
        finish_packet(3, 4, 1'b0);
    endtask

    task automatic test_size_clamp();
        samples[0] = 12'h5A7; nSamples = 1; sIdx = 0; sValidEn = 1'b1; expUnderrun = 1'b0;
        update_stream();
        expBytes[0] = 8'h7F; expBytes[1] = 8'h93; expBytes[2] = 8'h55; expBytes[3] = 8'h55;
        expBytes[4] = 8'hDE; expBytes[5] = 8'hBE; expBytes[6] = 8'hEF; expBytes[7] = 8'hA7;
        start_packet(1'b1, 16'hBEEF, 8'd3);
        run_packet(8, 8);
        finish_packet(2, 4, 1'b0);
    endtask

    task automatic test_underrun();
        samples[0] = 12'hFFF; samples[1] = 12'hFFF; samples[2] = 12'hFFF; samples[3] = 12'hFFF;
        nSamples = 4; sIdx = 0; sValidEn = 1'b0; expUnderrun = 1'b1;
        update_stream();
        expBytes[0] = 8'h7F; expBytes[1] = 8'h93; expBytes[2] = 8'hAA; expBytes[3] = 8'hAA;
        expBytes[4] = 8'hDE; expBytes[5] = 8'h0F; expBytes[6] = 8'h0F; expBytes[7] = 8'h00;
        expBytes[8] = 8'h00; expBytes[9] = 8'h00;
        start_packet(1'b0, 16'h0F0F, 8'd10);
        run_packet(10, 10);
        checks++;
        if (underrun !== 1'b1 || sIdx != 0) begin
            failures++;
            $display("[TB] FAIL underrun_end: ur=%b used=%0d want 1/0", underrun, sIdx);
        end
        finish_packet(2, 4, 1'b0);
    endtask

    task automatic test_gap();
        samples[0] = 12'h321; nSamples = 1; sIdx = 0; sValidEn = 1'b1; expUnderrun = 1'b0;
        update_stream();
        expBytes[0] = 8'h7F; expBytes[1] = 8'h93; expBytes[2] = 8'h55; expBytes[3] = 8'h55;
        expBytes[4] = 8'hDE; expBytes[5] = 8'hA5; expBytes[6] = 8'hC3; expBytes[7] = 8'h21;
        tx_wait = 16'd10;
        start_packet(1'b1, 16'hA5C3, 8'd8);
        run_packet(8, 8);
        finish_packet(5, 14, 1'b1);
        tx_wait = 16'd0;
    endtask

    task automatic test_reset_mid_packet();
        load_basic();
        start_packet(1'b0, 16'h1234, 8'd13);
        run_packet(13, 9);
        @(negedge clk);
        rstn = 1'b0;
        bus.load_next = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_in_reset: got %b want 0", bus.s_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bus.spi_stop !== 1'b0 || bus.spi_byte !== 8'h00 || underrun !== 1'b0
            || bus.spi_start !== 1'b0 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset: busy=%b stop=%b byte=%h ur=%b start=%b rdy=%b want 0",
                     busy, bus.spi_stop, bus.spi_byte, underrun, bus.spi_start, bus.s_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bus.spi_byte !== 8'h00 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_load: busy=%b byte=%h rdy=%b want 0/00/0",
                     busy, bus.spi_byte, bus.s_ready);
        end
        bus.load_next = 1'b0;
        load_basic();
        start_packet(1'b0, 16'h1234, 8'd13);
        run_packet(13, 13);
        checks++;
        if (sIdx != 4) begin
            failures++;
            $display("[TB] FAIL samples_after_reset: got %0d want 4", sIdx);
        end
        finish_packet(2, 4, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_size_clamp();
        test_underrun();
        test_gap();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cc1200_tx_framer.md
CC1200_TX_FRAMER -- requirements
Module: cc1200_tx_framer

Interface
REQ-001 Parameter SAMPLE_W, default 12, meaning payload sample width in bits; legal range 8..16.
REQ-002 Parameter SYNC0, default 32'h93AAAADE, meaning the sync word sent when frame_sync=0.
REQ-003 Parameter SYNC1, default 32'h935555DE, meaning the sync word sent when frame_sync=1.
REQ-004 Parameter CMD, default 8'h7F, meaning the CC1200 burst-TX-FIFO command byte.
REQ-005 Ports: clk in 1, the single clock; rstn in 1, reset that is synchronous and active-low.
REQ-006 Ports: trans_en in 1, TX mode enable; tran_en in 1, source has a frame ready; frame_sync in 1, selects SYNC0 or SYNC1; tran_add in 16, packet address.
REQ-007 Ports: s_data in SAMPLE_W, sample; s_valid in 1; s_ready out 1, sample consumed this cycle.
REQ-008 Ports: tx_pkt_size in 8, total SPI bytes per packet; tx_wait in 16, inter-packet gap in cycles; pkt_gpio in 1, CC1200 packet-sent GPIO.
REQ-009 Ports: load_next in 1, byte accepted by the SPI engine; spi_start out 1; spi_stop out 1; spi_byte out 8.
REQ-010 Ports: busy out 1; underrun out 1, sticky flag.

Function
REQ-011 States: IDLE, SEND, WAIT_HI, WAIT_LO, GAP.
REQ-012 IDLE->SEND when trans_en && tran_en; spi_start pulses 1 cycle on the transition cycle; frame_sync and tran_add are latched on that cycle.
REQ-013 Byte order in SEND: CMD, sync[31:24], [23:16], [15:8], [7:0], add[15:8], add[7:0], then payload.
REQ-014 spi_byte is combinational from byte_cnt and the packer; byte_cnt increments on each load_next in SEND.
REQ-015 Effective size = max(tx_pkt_size, 8), sampled at entry to SEND; spi_stop = 1 while byte_cnt == size-1 in SEND.
REQ-016 On load_next with byte_cnt == size-1: SEND->WAIT_HI.
REQ-017 Payload packing is LSB-first bitstream: each payload byte takes the next 8 accumulator bits; when fewer than 8 bits remain, a sample is appended above them.
REQ-018 A sample is pulled (s_ready=1 with s_valid=1) only in the cycle of a payload load_next that needs it; s_ready=0 otherwise.
REQ-019 If a sample is needed and s_valid=0: zero bits are substituted and underrun sets; underrun clears only on reset or IDLE->SEND.
REQ-020 Residual accumulator bits are discarded at packet end; each packet starts with an empty accumulator.
REQ-021 WAIT_HI->WAIT_LO on pkt_gpio=1; WAIT_LO->GAP on pkt_gpio=0, with pkt_gpio double-registered.
REQ-022 GAP counts 0..tx_wait, then ->IDLE; tx_wait=0 gives a 1-cycle GAP.
REQ-023 trans_en falling in SEND does not abort; the packet completes.
REQ-024 busy = (state != IDLE).

Reset
REQ-025 With rstn=0 at a clk edge: state=IDLE, all counters and accumulator 0, underrun=0, spi_start=0, spi_stop=0, s_ready=0, spi_byte=8'h00.
REQ-026 Reset mid-packet aborts immediately, and no further load_next is honoured until a new start.

Structure
REQ-027 Package cc1200_pkg holds the state enum, default sync words, CMD, and header length 7.
REQ-028 Sub-module cc1200_bit_packer (SAMPLE_W-parametrised accumulator, pull/ready logic) is instantiated once.

Verification
REQ-029 SAMPLE_W=12, size=13, frame_sync=0, add=16'h1234, samples 12'hABC, 12'h123, 12'h456, 12'h789 -> bytes 7F 93 AA AA DE 12 34 BC 3A 12 56 94 78; spi_stop on byte 13.
REQ-030 frame_sync=1, size=3 -> size clamped to 8; bytes 7F 93 55 55 DE add_hi add_lo, then one payload byte.
REQ-031 s_valid=0 throughout payload -> payload bytes 00, underrun=1 after the first payload load_next, and underrun cleared at the next start.
REQ-032 Drive pkt_gpio high for 5 cycles, then low, with tx_wait=10 -> busy drops 11 GAP cycles after the synchronised fall; a new tran_en is ignored until IDLE.
REQ-033 rstn=0 during payload byte 3 -> all outputs reach their reset values on the next edge; a subsequent packet begins with CMD 7F.
